spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
Receiving end of the neuron spike bus. Samples the 8-lane spike vector on each strobe and counts spikes per lane over a fixed window of strobes. At each window end it snapshots the counts and streams them out one lane per beat over a valid/ready interface. Sits between the time-multiplexed LIF array and the readout/host logic.

Parameters:
N_CH, 8, number of spike lanes (power of two, ≥2)
WINDOW, 16, strobes per accumulation window (≥2)
CNT_W, 5, count width; must satisfy 2^CNT_W-1 ≥ WINDOW

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-high (1 = reset), despite the codebase name
spike  in  N_CH  spike vector from neuron array
spike_valid  in  1  sample strobe; spike counted only when 1
out_valid  out  1  output beat available
out_ready  in  1  consumer accepts beat
out_chan  out  $clog2(N_CH)  lane index of current beat
out_count  out  CNT_W  spike count of that lane for the snapshotted window
out_last  out  1  high on lane N_CH-1 beat
overrun  out  1  sticky: a window ended while the drain was still in progress

Behaviour:
- Reset (rst_n=1 at edge): all accumulators 0, window counter 0, snapshot regs 0, FSM IDLE, out_valid=0, out_chan=0, out_count=0, out_last=0, overrun=0. Reset mid-drain aborts the drain; the partial snapshot is discarded.
- Accumulation (always active, independent of FSM): on a cycle with spike_valid=1, acc[i] += spike[i] per lane; saturate at 2^CNT_W-1 (unreachable with legal params, still required). win_cnt increments by 1, 0..WINDOW-1.
- Window end: the strobe with win_cnt==WINDOW-1 counts its own spikes, then win_cnt wraps to 0. On that same edge, acc+current spikes are copied to the snapshot and acc clears to 0 (the next strobe starts a fresh window; no lost or double-counted sample).
- Snapshot is taken only if FSM is IDLE. If FSM is DRAIN: snapshot not updated (the old drain continues unchanged), the new window's counts are dropped, acc still clears, and overrun is set to 1 (sticky until reset).
- FSM states:
  IDLE: out_valid=0. On a window-end snapshot, go to DRAIN with chan=0.
  DRAIN: out_valid=1, out_chan=chan, out_count=snap[chan], out_last=(chan==N_CH-1). A beat transfers when out_valid & out_ready. On transfer with chan<N_CH-1, chan++. On transfer with chan==N_CH-1, go to IDLE.
- Latency: out_valid rises the cycle after the window-end strobe edge (registered outputs). Back-to-back ready drains in N_CH cycles.
- Out signals stay stable while out_valid=1 and out_ready=0 (AXI-style; valid never drops without a transfer).
- The window-end transfer of the last beat and a new snapshot can occur on the same edge. The FSM is in DRAIN at that edge, so this counts as overrun. Required: overrun=1 and the next snapshot is dropped.
- spike_valid=0 cycles: no change to acc or win_cnt.

Optional Feature:
Macro: SPIKE_DECODER_TTFS_EN
- Defined: add output out_ttfs [$clog2(WINDOW)] and per-lane first-spike registers. Each register records the win_cnt of the lane's first spike in the window, or WINDOW-1 if there was no spike. It is snapshotted and reset with the counts and presented alongside out_count with the same handshake. A lane is flagged "no spike" by out_count==0.
- Undefined: no port, no registers; behaviour otherwise identical.

Decomposition:
- Package spike_pkg: FSM state enum (IDLE, DRAIN), localparams CH_W=$clog2(N_CH) and WIN_W=$clog2(WINDOW), and a saturating-increment function.
- One sub-module: spike_lane_acc (one lane: saturating counter, optional TTFS capture, clear/snapshot ports), instantiated N_CH times via generate.

Test Plan:
- Reset then all-zero spikes, spike_valid=1 for 16 cycles, out_ready=1 -> 8 beats with chan 0..7, count 0, out_last on beat 7, overrun=0.
- spike=8'b1010_0101 on every strobe for 16 strobes -> counts 16,0,16,0,0,16,0,16 (lanes 0..7).
- spike_valid toggled 1/0 over 32 cycles, spike=8'hFF -> window ends after 16 strobes (cycle 31); all counts 16.
- out_ready=0 for the whole next window -> out_chan stays 0 with values stable; overrun=1 at the 2nd window end; later drain shows 1st window's counts.
- Assert rst_n=1 at beat 3 of a drain -> next cycle out_valid=0, overrun=0, acc cleared, next window counts from 0.
- SPIKE_DECODER_TTFS_EN: lane 2 first spikes at strobe 5, lane 7 never -> out_ttfs=5 for lane 2 and 15 for lane 7 with out_count=0.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared types, default sizing and the saturating-increment helper for spike_rate_decoder.
package spike_pkg;

  localparam int DEF_N_CH   = 8;
  localparam int DEF_WINDOW = 16;
  localparam int DEF_CNT_W  = 5;
  localparam int CH_W       = $clog2(DEF_N_CH);
  localparam int WIN_W      = $clog2(DEF_WINDOW);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Returns v+1, holding at max_v once reached.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max_v);
    return (v >= max_v) ? v : v + 1;
  endfunction

endpackage

// File: rtl/spike_lane_acc.sv
// One spike lane: saturating window counter plus snapshot register.
// With SPIKE_DECODER_TTFS_EN defined it also captures the window index of the first spike.
module spike_lane_acc
  import spike_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
`ifdef SPIKE_DECODER_TTFS_EN
  ,
  parameter int WINDOW = DEF_WINDOW
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_spike,
  input  logic                       i_strobe,
  input  logic                       i_clear,
  input  logic                       i_snap,
`ifdef SPIKE_DECODER_TTFS_EN
  input  logic [$clog2(WINDOW)-1:0]  i_win_idx,
  output logic [$clog2(WINDOW)-1:0]  o_snap_ttfs,
`endif
  output logic [CNT_W-1:0]           o_snap_count
);

  localparam int unsigned CNT_MAX = (2 ** CNT_W) - 1;

  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_snap;
  logic [CNT_W-1:0] w_acc_next;

  // The closing strobe's own spike is folded into the snapshot value.
  assign w_acc_next = i_spike ? CNT_W'(sat_inc(32'(r_acc), CNT_MAX)) : r_acc;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_acc  <= '0;
      r_snap <= '0;
    end else if (i_strobe) begin
      r_acc <= i_clear ? '0 : w_acc_next;
      if (i_snap) r_snap <= w_acc_next;
    end
  end

  assign o_snap_count = r_snap;

`ifdef SPIKE_DECODER_TTFS_EN
  localparam int WW = $clog2(WINDOW);

  logic [WW-1:0] r_first;
  logic [WW-1:0] r_snap_ttfs;
  logic [WW-1:0] w_first_next;

  // A zero count means no spike yet this window, so this strobe is the first one.
  assign w_first_next = (i_spike && (r_acc == '0)) ? i_win_idx : r_first;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_first     <= WW'(WINDOW - 1);
      r_snap_ttfs <= '0;
    end else if (i_strobe) begin
      r_first <= i_clear ? WW'(WINDOW - 1) : w_first_next;
      if (i_snap) r_snap_ttfs <= w_first_next;
    end
  end

  assign o_snap_ttfs = r_snap_ttfs;
`endif

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes per lane over WINDOW strobes and streams the snapshot out one lane per beat.
// Optional macro SPIKE_DECODER_TTFS_EN adds out_ttfs (first-spike time per lane).
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter int N_CH   = DEF_N_CH,
  parameter int WINDOW = DEF_WINDOW,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           spike,
  input  logic                      spike_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [$clog2(N_CH)-1:0]   out_chan,
  output logic [CNT_W-1:0]          out_count,
  output logic                      out_last,
  output logic                      overrun
`ifdef SPIKE_DECODER_TTFS_EN
  ,
  output logic [$clog2(WINDOW)-1:0] out_ttfs
`endif
);

  localparam int CHW = $clog2(N_CH);
  localparam int WW  = $clog2(WINDOW);

  state_e           r_state;
  state_e           w_state_next;
  logic [CHW-1:0]   r_chan;
  logic [CHW-1:0]   w_chan_next;
  logic [WW-1:0]    r_win_cnt;
  logic             r_overrun;
  logic             w_win_end;
  logic             w_snap;
  logic             w_xfer;
  logic [CNT_W-1:0] w_snap_count [N_CH];
`ifdef SPIKE_DECODER_TTFS_EN
  logic [WW-1:0]    w_snap_ttfs [N_CH];
`endif

  assign w_win_end = spike_valid && (r_win_cnt == WW'(WINDOW - 1));
  assign w_snap    = w_win_end && (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_win_cnt <= '0;
    end else if (spike_valid) begin
      r_win_cnt <= w_win_end ? '0 : r_win_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    spike_lane_acc #(
      .CNT_W (CNT_W)
`ifdef SPIKE_DECODER_TTFS_EN
      ,
      .WINDOW(WINDOW)
`endif
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_spike     (spike[g]),
      .i_strobe    (spike_valid),
      .i_clear     (w_win_end),
      .i_snap      (w_snap),
`ifdef SPIKE_DECODER_TTFS_EN
      .i_win_idx   (r_win_cnt),
      .o_snap_ttfs (w_snap_ttfs[g]),
`endif
      .o_snap_count(w_snap_count[g])
    );
  end

  // Handshake: a beat moves on any edge where out_valid && out_ready; while out_valid is
  // high and out_ready low, all out_* hold, and out_valid only drops after the last beat moves.
  assign w_xfer = (r_state == DRAIN) && out_ready;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= IDLE;
      r_chan  <= '0;
    end else begin
      r_state <= w_state_next;
      r_chan  <= w_chan_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_chan_next  = r_chan;
    case (r_state)
      IDLE: begin
        if (w_snap) begin
          w_state_next = DRAIN;
          w_chan_next  = '0;
        end
      end
      DRAIN: begin
        if (w_xfer) begin
          if (r_chan == CHW'(N_CH - 1)) begin
            w_state_next = IDLE;
            w_chan_next  = '0;
          end else begin
            w_chan_next = r_chan + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_chan_next  = '0;
      end
    endcase
  end

  // A window closing mid-drain is dropped; remember it until reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_overrun <= 1'b0;
    end else if (w_win_end && (r_state == DRAIN)) begin
      r_overrun <= 1'b1;
    end
  end

  assign out_valid = (r_state == DRAIN);
  assign out_chan  = r_chan;
  assign out_count = out_valid ? w_snap_count[r_chan] : '0;
  assign out_last  = out_valid && (r_chan == CHW'(N_CH - 1));
  assign overrun   = r_overrun;
`ifdef SPIKE_DECODER_TTFS_EN
  assign out_ttfs  = out_valid ? w_snap_ttfs[r_chan] : '0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: window counting, drain handshake, overrun, reset, TTFS.
module tb_spike_rate_decoder;

  localparam int N_CH  = 8;
  localparam int CNT_W = 5;
  localparam int WIN_W = 4;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [N_CH-1:0]  spike = '0;
  logic             spike_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             out_valid;
  logic [2:0]       out_chan;
  logic [CNT_W-1:0] out_count;
  logic             out_last;
  logic             overrun;
`ifdef SPIKE_DECODER_TTFS_EN
  logic [WIN_W-1:0] out_ttfs;
`endif

  always #5 clk = ~clk;

  spike_rate_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike      (spike),
    .spike_valid(spike_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_chan   (out_chan),
    .out_count  (out_count),
    .out_last   (out_last),
    .overrun    (overrun)
`ifdef SPIKE_DECODER_TTFS_EN
    ,
    .out_ttfs   (out_ttfs)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [CNT_W-1:0] exp_q[$];
  logic [WIN_W-1:0] exp_ttfs_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Constant pattern for n strobes: lane count n or 0, first spike at index 0 or none (15).
  task automatic push_const(input logic [N_CH-1:0] pat, input int n);
    for (int i = 0; i < N_CH; i++) begin
      exp_q.push_back(pat[i] ? CNT_W'(n) : CNT_W'(0));
      exp_ttfs_q.push_back(pat[i] ? WIN_W'(0) : WIN_W'(15));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_window(input logic [N_CH-1:0] pat, input int n, input bit gap,
                            input bit chk_lat);
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      if (chk_lat && s == n - 1) chk("lat_early", out_valid, 0);
      spike       = pat;
      spike_valid = 1'b1;
      if (gap) begin
        @(negedge clk);
        spike_valid = 1'b0;
      end
    end
    if (!gap) begin
      @(negedge clk);
      spike_valid = 1'b0;
    end
    if (chk_lat) chk("lat_rise", out_valid, 1);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    logic [CNT_W-1:0] ec;
    logic [WIN_W-1:0] et;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("%s_valid_wait", tag), out_valid, 1);
    out_ready = 1'b1;
    for (int b = 0; b < N_CH; b++) begin
      ec = exp_q.pop_front();
      et = exp_ttfs_q.pop_front();
      chk($sformatf("%s_valid%0d", tag, b), out_valid, 1);
      chk($sformatf("%s_chan%0d", tag, b), out_chan, b);
      chk($sformatf("%s_cnt%0d", tag, b), out_count, ec);
      chk($sformatf("%s_last%0d", tag, b), out_last, (b == N_CH - 1));
`ifdef SPIKE_DECODER_TTFS_EN
      chk($sformatf("%s_ttfs%0d", tag, b), out_ttfs, et);
`endif
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk($sformatf("%s_done", tag), out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_count", out_count, 0);
    chk("rst_last", out_last, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b0;

    // all-zero window with consumer always ready
    out_ready = 1'b1;
    push_const(8'h00, 16);
    run_window(8'h00, 16, 1'b0, 1'b1);
    drain("w_zero");
    chk("zero_overrun", overrun, 0);

    push_const(8'hA5, 16);
    run_window(8'hA5, 16, 1'b0, 1'b1);
    drain("w_a5");

    // strobes every other cycle; gap cycles carry spikes that must not count
    push_const(8'hFF, 16);
    run_window(8'hFF, 16, 1'b1, 1'b1);
    drain("w_gap");

    // consumer stalls through a whole second window
    push_const(8'h3C, 16);
    run_window(8'h3C, 16, 1'b0, 1'b1);
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      if (s % 4 == 3) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_chan", out_chan, 0);
        chk("hold_count", out_count, exp_q[0]);
        chk("hold_overrun_pre", overrun, 0);
      end
      spike       = 8'hFF;
      spike_valid = 1'b1;
    end
    @(negedge clk);
    spike_valid = 1'b0;
    chk("hold_overrun", overrun, 1);
    chk("hold_chan_end", out_chan, 0);
    drain("w_hold");
    chk("overrun_sticky", overrun, 1);

    // reset in the middle of a drain, with strobes arriving during the drain
    run_window(8'hFF, 16, 1'b0, 1'b1);
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("pre_rst_chan%0d", b), out_chan, b);
      chk($sformatf("pre_rst_cnt%0d", b), out_count, 16);
      out_ready   = 1'b1;
      spike       = 8'hFF;
      spike_valid = 1'b1;
      @(negedge clk);
    end
    chk("pre_rst_chan3", out_chan, 3);
    rst_n     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n       = 1'b0;
    spike_valid = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_chan", out_chan, 0);
    chk("mid_rst_count", out_count, 0);
    push_const(8'h01, 16);
    run_window(8'h01, 16, 1'b0, 1'b1);
    drain("post_rst");

    // last beat transfers on the same edge a new window closes
    push_const(8'h80, 16);
    run_window(8'h80, 16, 1'b0, 1'b1);
    chk("edge_overrun_pre", overrun, 0);
    for (int c = 0; c < 16; c++) begin
      if (c >= 8) begin
        chk($sformatf("edge_chan%0d", c - 8), out_chan, c - 8);
        chk($sformatf("edge_cnt%0d", c - 8), out_count, exp_q.pop_front());
        void'(exp_ttfs_q.pop_front());
      end
      spike       = 8'hFF;
      spike_valid = 1'b1;
      out_ready   = (c >= 8);
      @(negedge clk);
    end
    spike_valid = 1'b0;
    out_ready   = 1'b0;
    chk("edge_valid", out_valid, 0);
    chk("edge_overrun", overrun, 1);
    repeat (3) @(negedge clk);
    chk("edge_dropped", out_valid, 0);

`ifdef SPIKE_DECODER_TTFS_EN
    // lane 0 every strobe, lane 2 from strobe 5, lane 7 never
    for (int i = 0; i < N_CH; i++) begin
      exp_q.push_back(i == 0 ? CNT_W'(16) : (i == 2 ? CNT_W'(11) : CNT_W'(0)));
      exp_ttfs_q.push_back(i == 0 ? WIN_W'(0) : (i == 2 ? WIN_W'(5) : WIN_W'(15)));
    end
    for (int s = 0; s < 16; s++) begin
      @(negedge clk);
      spike       = (s >= 5) ? 8'h05 : 8'h01;
      spike_valid = 1'b1;
    end
    @(negedge clk);
    spike_valid = 1'b0;
    drain("ttfs");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
